// File: rtl/sort_job_ctrl_pkg.sv
// Shared defaults and state encoding for the sort job controller.
package sort_job_ctrl_pkg;

  localparam int N_DEF       = 32;
  localparam int W_DEF       = 7;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

endpackage

// File: rtl/sort_job_ctrl_buf.sv
// N x W job buffer: one indexed write port, one whole-buffer load from the
// sorter, a flattened parallel read and one indexed read.
module sort_job_ctrl_buf
  import sort_job_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 ld_en,
  input  logic [N*W-1:0]       ld_data,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [W-1:0]         rd_data,
  output logic [N*W-1:0]       flat
);

  logic [N*W-1:0] mem_q;
  logic [N*W-1:0] mem_d;

  // The sorter load wins; the FSM never asserts both in the same cycle.
  always_comb begin
    mem_d = mem_q;
    if (ld_en) begin
      mem_d = ld_data;
    end else if (wr_en) begin
      mem_d[int'(wr_addr)*W +: W] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[int'(rd_addr)*W +: W];
  assign flat    = mem_q;

endmodule

// File: rtl/sort_job_ctrl.sv
// Streaming job sequencer around the 32-entry bubble sorter: load N words,
// run the sorter, stream the sorted words out, then ack the sorter to idle.
module sort_job_ctrl
  import sort_job_ctrl_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic           sort_start,
  output logic           sort_ack,
  input  logic           sort_done,
  output logic [N*W-1:0] sort_a,
  input  logic [N*W-1:0] sort_b,
  output logic           busy,
  output logic           timeout_err
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             sort_start_q, sort_start_d;
  logic             sort_ack_q, sort_ack_d;
  logic             busy_q, busy_d;
  logic             wr_en;
  logic             ld_en;

  sort_job_ctrl_buf #(
    .N (N),
    .W (W)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (in_data),
    .ld_en   (ld_en),
    .ld_data (sort_b),
    .rd_addr (idx_q),
    .rd_data (out_data),
    .flat    (sort_a)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    wr_en         = 1'b0;
    ld_en         = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          wr_en = 1'b1;
          if (idx_q == '0) begin
            timeout_err_d = 1'b0;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sort_done) begin
          ld_en   = 1'b1;
          idx_d   = '0;
          state_d = ST_UNLOAD;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_ACK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (!sort_done) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d   = (state_d == ST_LOAD);
    out_valid_d  = (state_d == ST_UNLOAD);
    out_last_d   = (state_d == ST_UNLOAD) && (idx_d == IDX_LAST);
    sort_start_d = (state_d == ST_START);
    sort_ack_d   = (state_d == ST_ACK);
    busy_d       = !((state_d == ST_LOAD) && (idx_d == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_LOAD;
      idx_q         <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      sort_start_q  <= 1'b0;
      sort_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      sort_start_q  <= sort_start_d;
      sort_ack_q    <= sort_ack_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign sort_start  = sort_start_q;
  assign sort_ack    = sort_ack_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Bench for sort_job_ctrl with a behavioural sorter of programmable done latency.
module tb_sort_job_ctrl;

  localparam int N   = 32;
  localparam int W   = 7;
  localparam int TMO = 4096;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic           sort_start;
  logic           sort_ack;
  logic           sort_done;
  logic [N*W-1:0] sort_a;
  logic [N*W-1:0] sort_b;
  logic           busy;
  logic           timeout_err;

  int checks   = 0;
  int failures = 0;
  bit model_never = 1'b0;
  int model_lat   = 40;
  bit chk_no_inready = 1'b0;
  int job_w[N];
  int exp_q[$];

  always #5 clk = ~clk;

  sort_job_ctrl #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .sort_start  (sort_start),
    .sort_ack    (sort_ack),
    .sort_done   (sort_done),
    .sort_a      (sort_a),
    .sort_b      (sort_b),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Behavioural sorter: sees start, waits model_lat cycles, presents the
  // sorted words with done high until ack; reset returns it to idle.
  initial begin : sorter_model
    int vals[$];
    int cnt;
    sort_done = 1'b0;
    sort_b    = '0;
    forever begin
      @(negedge clk);
      if (reset_n && sort_start && !model_never) begin
        vals = {};
        for (int i = 0; i < N; i++) vals.push_back(int'(sort_a[i*W +: W]));
        vals.sort();
        cnt = 0;
        while (cnt < model_lat && reset_n) begin
          @(negedge clk);
          cnt++;
        end
        if (reset_n) begin
          for (int i = 0; i < N; i++) sort_b[i*W +: W] = W'(vals[i]);
          sort_done = 1'b1;
          while (reset_n && !sort_ack) @(negedge clk);
        end
        sort_done = 1'b0;
      end
    end
  end

  task automatic make_expected();
    exp_q = {};
    for (int i = 0; i < N; i++) exp_q.push_back(job_w[i]);
    exp_q.sort();
  endtask

  task automatic send_words(input int from, input int to_excl, input int gap_pct);
    int i;
    int cyc;
    i = from;
    cyc = 0;
    while (i < to_excl && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = W'(job_w[i]);
      end
      if (in_valid && in_ready) i++;
    end
    checks++;
    if (i < to_excl) begin
      failures++;
      $display("FAIL send_timeout: accepted %0d words, required %0d", i - from, to_excl - from);
    end
  endtask

  task automatic recv_words(input int stop_at, input int stall_pct);
    int k;
    int cyc;
    bit stalled;
    logic [W-1:0] held;
    logic held_last;
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    held_last = 1'b0;
    while (k < stop_at && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (chk_no_inready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_busy: got %b required 0", in_ready);
        end
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held || out_last !== held_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%b d=%0d l=%b required v=1 d=%0d l=%b",
                   out_valid, out_data, out_last, held, held_last);
        end
      end
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      stalled = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          checks++;
          if (out_data !== W'(exp_q[k]) || out_last !== (k == N - 1)) begin
            failures++;
            $display("FAIL out_word[%0d]: got d=%0d l=%b required d=%0d l=%b",
                     k, out_data, out_last, exp_q[k], (k == N - 1));
          end
          k++;
        end else begin
          stalled = 1'b1;
          held = out_data;
          held_last = out_last;
        end
      end
    end
    checks++;
    if (k < stop_at) begin
      failures++;
      $display("FAIL recv_timeout: got %0d words required %0d", k, stop_at);
    end
  endtask

  task automatic wait_idle(input string name);
    bit seen_ack;
    seen_ack = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (sort_ack === 1'b1) seen_ack = 1'b1;
      if (in_ready === 1'b1 && busy === 1'b0) break;
    end
    checks++;
    if (!seen_ack || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got ack_seen=%b in_ready=%b busy=%b out_valid=%b required 1 1 0 0",
               name, seen_ack, in_ready, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, sort_start, sort_ack, busy, timeout_err} !== 7'b0 ||
        sort_a !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_values: got ctl=%b a_nonzero=%b required 0000000 0",
               {in_ready, out_valid, out_last, sort_start, sort_ack, busy, timeout_err},
               (sort_a !== '0));
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_release: got %b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_release: got rdy=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_descending();
    for (int i = 0; i < N; i++) job_w[i] = N - 1 - i;
    make_expected();
    model_lat = 600;
    send_words(0, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sort_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: got start=%b rdy=%b busy=%b required 1 0 1",
               sort_start, in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (sort_start !== 1'b0) begin
      failures++;
      $display("FAIL start_pulse_width: got %b required 0", sort_start);
    end
    recv_words(N, 0);
    wait_idle("descending");
  endtask

  task automatic test_dups();
    int lst[N] = '{30,22,23,21,13,14,16,12,20,19,28,17,27,24,18,25,
                   26,16,9,11,6,12,31,7,8,10,5,4,3,2,1,0};
    for (int i = 0; i < N; i++) job_w[i] = lst[i];
    make_expected();
    model_lat = 50;
    send_words(0, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    recv_words(N, 0);
    wait_idle("dups");
  endtask

  task automatic test_random_stalls();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) job_w[i] = int'($urandom_range(127));
      make_expected();
      model_lat = int'($urandom_range(120, 33));
      send_words(0, N, 50);
      @(negedge clk);
      in_valid = 1'b0;
      recv_words(N, 50);
      wait_idle("random");
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < N; i++) job_w[i] = int'($urandom_range(127));
    model_never = 1'b1;
    send_words(0, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sort_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_start: got %b required 1", sort_start);
    end
    repeat (TMO) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || sort_ack !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early: got err=%b ack=%b required 0 0", timeout_err, sort_ack);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || sort_ack !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fire: got err=%b ack=%b ov=%b required 1 1 0",
               timeout_err, sort_ack, out_valid);
    end
    @(negedge clk);
    checks++;
    if (sort_ack !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_back_to_load: got ack=%b rdy=%b busy=%b err=%b required 0 1 0 1",
               sort_ack, in_ready, busy, timeout_err);
    end
    model_never = 1'b0;
    for (int i = 0; i < N; i++) job_w[i] = int'($urandom_range(127));
    make_expected();
    model_lat = 45;
    send_words(0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_clear: got err=%b busy=%b required 0 1", timeout_err, busy);
    end
    send_words(1, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    recv_words(N, 0);
    wait_idle("after_tmo");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) job_w[i] = int'($urandom_range(127));
    make_expected();
    model_lat = 40;
    send_words(0, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    recv_words(10, 0);
    @(posedge clk);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, sort_start, sort_ack, busy, timeout_err} !== 7'b0 ||
        sort_a !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_values: got ctl=%b d=%0d a_nonzero=%b required 0000000 0 0",
               {in_ready, out_valid, out_last, sort_start, sort_ack, busy, timeout_err},
               out_data, (sort_a !== '0));
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || sort_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release: got rdy=%b busy=%b done=%b required 1 0 0",
               in_ready, busy, sort_done);
    end
    for (int i = 0; i < N; i++) job_w[i] = int'($urandom_range(127));
    make_expected();
    model_lat = 60;
    send_words(0, N, 20);
    @(negedge clk);
    in_valid = 1'b0;
    recv_words(N, 30);
    wait_idle("after_reset");
  endtask

  task automatic test_back_to_back();
    int job_b[N];
    for (int i = 0; i < N; i++) begin
      job_w[i] = int'($urandom_range(127));
      job_b[i] = int'($urandom_range(127));
    end
    make_expected();
    model_lat = 35;
    send_words(0, N, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'(job_b[0]);
    checks++;
    if (sort_start !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start: got start=%b rdy=%b required 1 0", sort_start, in_ready);
    end
    chk_no_inready = 1'b1;
    recv_words(N, 0);
    chk_no_inready = 1'b0;
    @(negedge clk);
    checks++;
    if (sort_ack !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack: got ack=%b rdy=%b required 1 0", sort_ack, in_ready);
    end
    for (int i = 0; i < N; i++) job_w[i] = job_b[i];
    make_expected();
    send_words(0, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    recv_words(N, 0);
    wait_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_descending();
    test_dups();
    test_random_stalls();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
